// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FSM state type and Gray-to-binary helper
package fifo_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search starting at ptr, wrapping modulo NREQ
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  // scan from the farthest candidate back to ptr so the nearest requester wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % NREQ] = 1'b1;
        idx = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-granular round-robin write arbiter for an async FIFO; FIFO_WR_ARB_SPACE_CHECK_EN enables the free-space gate
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int ADDRSIZE  = 4,
  parameter int MIN_SPACE = 4
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DSIZE-1:0]   din,
  input  logic [NREQ-1:0]         dlast,
  output logic [NREQ-1:0]         ack,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  input  logic                    wfull,
  input  logic [ADDRSIZE:0]       wptr,
  input  logic [ADDRSIZE:0]       wq2_rptr,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);
  localparam int IW = $clog2(NREQ);
  state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, win_idx;
  logic [NREQ-1:0] win_gnt;
  logic space_ok;
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req(req),
    .ptr(rr_ptr_q),
    .gnt(win_gnt),
    .idx(win_idx)
  );
  assign busy  = state_q == BURST;
  assign ack   = (busy && !wfull) ? (req & (NREQ'(1) << owner_q)) : '0;
  assign winc  = |ack;
  assign wdata = din[owner_q*DSIZE +: DSIZE];
  assign owner = owner_q;
`ifdef FIFO_WR_ARB_SPACE_CHECK_EN
  logic [ADDRSIZE:0] wbin, rbin, used;
  assign wbin = (ADDRSIZE+1)'(gray2bin(32'(wptr)));
  assign rbin = (ADDRSIZE+1)'(gray2bin(32'(wq2_rptr)));
  assign used = wbin - rbin;
  assign space_ok = 32'(used) + 32'(MIN_SPACE) <= (32'd1 << ADDRSIZE);
`else
  logic unused_ptrs;
  assign unused_ptrs = ^{wptr, wq2_rptr};
  assign space_ok = 1'b1;
`endif
  // grant in IDLE when someone asks and room exists; release after the owner's last beat
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (!busy && |win_gnt && space_ok) begin
      state_d = BURST;
      owner_d = win_idx;
    end
    if (winc && dlast[owner_q]) begin
      state_d  = IDLE;
      rr_ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    end
  end
  // state, owner and round-robin pointer registers
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule
